// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and the
// helper that classifies which modes advance the shift counter.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t USR_HOLD = 3'b000;
  localparam usr_mode_t USR_SHR  = 3'b001;
  localparam usr_mode_t USR_SHL  = 3'b010;
  localparam usr_mode_t USR_LOAD = 3'b011;
  localparam usr_mode_t USR_ROR  = 3'b100;
  localparam usr_mode_t USR_ROL  = 3'b101;
  localparam usr_mode_t USR_ASR  = 3'b110;
  localparam usr_mode_t USR_CLR  = 3'b111;

  // Every mode that moves bits sideways counts toward a completed word.
  function automatic logic usr_is_shift(input usr_mode_t m);
    return (m == USR_SHR) || (m == USR_SHL) || (m == USR_ROR) ||
           (m == USR_ROL) || (m == USR_ASR);
  endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register: selects the next value of its bit
// from itself, its neighbours (or the edge substitutes), or the load data.
module usr_cell
  import usr_pkg::*;
(
  input  usr_mode_t mode,
  input  logic      cur,
  input  logic      shr_in,
  input  logic      shl_in,
  input  logic      ror_in,
  input  logic      rol_in,
  input  logic      asr_in,
  input  logic      d_bit,
  output logic      nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      USR_HOLD: nxt = cur;
      USR_SHR:  nxt = shr_in;
      USR_SHL:  nxt = shl_in;
      USR_LOAD: nxt = d_bit;
      USR_ROR:  nxt = ror_in;
      USR_ROL:  nxt = rol_in;
      USR_ASR:  nxt = asr_in;
      USR_CLR:  nxt = 1'b0;
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with serial outputs and a shift counter
// that pulses word_done once every WIDTH shifts (parallel<->serial conversion).
module usr_param
  import usr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  usr_mode_t        mode,
  input  logic             s_left,
  input  logic             s_right,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so_right,
  output logic             so_left,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_next;

  // Edge bits take serial inputs, wrap-around or sign bit in place of a neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shr_in, shl_in, ror_in, rol_in, asr_in;

    if (i == WIDTH - 1) begin : g_msb
      assign shr_in = s_right;
      assign ror_in = q[0];
      assign asr_in = q[WIDTH-1];
    end else begin : g_upper
      assign shr_in = q[i+1];
      assign ror_in = q[i+1];
      assign asr_in = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign shl_in = s_left;
      assign rol_in = q[WIDTH-1];
    end else begin : g_lower
      assign shl_in = q[i-1];
      assign rol_in = q[i-1];
    end

    usr_cell u_cell (
      .mode   (mode),
      .cur    (q[i]),
      .shr_in (shr_in),
      .shl_in (shl_in),
      .ror_in (ror_in),
      .rol_in (rol_in),
      .asr_in (asr_in),
      .d_bit  (d[i]),
      .nxt    (q_next[i])
    );
  end

  assign so_right = q[0];
  assign so_left  = q[WIDTH-1];

  // word_done drops on every edge that is not a wrapping shift, including ce=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (ce) begin
        q <= q_next;
        if (mode == USR_LOAD || mode == USR_CLR) begin
          shift_cnt <= '0;
        end else if (usr_is_shift(mode)) begin
          if (shift_cnt == LAST_CNT) begin
            shift_cnt <= '0;
            word_done <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usr_param.sv
// Self-checking bench for usr_param at WIDTH=4 and WIDTH=8, using a queue of
// expected results pushed as each stimulus step is driven.
module tb_usr_param;
  import usr_pkg::*;

  typedef struct packed {
    logic       ce;
    usr_mode_t  mode;
    logic       sl;
    logic       sr;
    logic [3:0] d;
    logic [3:0] q;
    logic [2:0] cnt;
    logic       done;
  } step_t;

  // observed/expected view: q, count, word_done, so_right, so_left
  typedef logic [9:0] obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  usr_mode_t  mode = USR_HOLD;
  logic       s_left = 1'b0;
  logic       s_right = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] q;
  logic       so_right, so_left;
  logic [2:0] shift_cnt;
  logic       word_done;

  logic       ce8 = 1'b0;
  usr_mode_t  mode8 = USR_HOLD;
  logic       s_left8 = 1'b0;
  logic       s_right8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [7:0] q8;
  logic       so_right8, so_left8;
  logic [3:0] shift_cnt8;
  logic       word_done8;

  int checks = 0;
  int failures = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  usr_param #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .s_left(s_left),
    .s_right(s_right), .d(d), .q(q), .so_right(so_right), .so_left(so_left),
    .shift_cnt(shift_cnt), .word_done(word_done)
  );

  usr_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ce(ce8), .mode(mode8), .s_left(s_left8),
    .s_right(s_right8), .d(d8), .q(q8), .so_right(so_right8), .so_left(so_left8),
    .shift_cnt(shift_cnt8), .word_done(word_done8)
  );

  function automatic step_t st(input logic c, input usr_mode_t m, input logic sl,
                               input logic sr, input logic [3:0] dv, input logic [3:0] eq,
                               input logic [2:0] ec, input logic ed);
    return {c, m, sl, sr, dv, eq, ec, ed};
  endfunction

  // Drives one step and queues what the register must show after the edge.
  task automatic apply_stimulus(input step_t s);
    @(negedge clk);
    ce = s.ce; mode = s.mode; s_left = s.sl; s_right = s.sr; d = s.d;
    sb.push_back({s.q, s.cnt, s.done, s.q[0], s.q[3]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    checks++;
    if ({q, shift_cnt, word_done} !== 8'h00 || q8 !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_initial got q=%b cnt=%0d wd=%b q8=%h want 0", q, shift_cnt, word_done, q8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(st(1'b1, USR_LOAD, 1'b0, 1'b0, 4'hA, 4'hA, 3'd0, 1'b0));
    got = {q, shift_cnt, word_done, so_right, so_left};
    checks++;
    if (got !== sb.pop_front()) begin
      failures++;
      $display("[TB] FAIL reset_load got=%b want q=1010", got);
    end
    apply_stimulus(st(1'b1, USR_SHR, 1'b0, 1'b1, 4'h0, 4'hD, 3'd1, 1'b0));
    got = {q, shift_cnt, word_done, so_right, so_left};
    checks++;
    if (got !== sb.pop_front()) begin
      failures++;
      $display("[TB] FAIL reset_shr got=%b want q=1101 cnt=1", got);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({q, shift_cnt, word_done} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_async got q=%b cnt=%0d wd=%b want 0", q, shift_cnt, word_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_steps(input string name, input step_t s[]);
    obs_t got, want;
    foreach (s[i]) begin
      apply_stimulus(s[i]);
      got = {q, shift_cnt, word_done, so_right, so_left};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL %s step %0d got q=%b cnt=%0d wd=%b sor=%b sol=%b want q=%b cnt=%0d wd=%b sor=%b sol=%b",
                 name, i, got[9:6], got[5:3], got[2], got[1], got[0],
                 want[9:6], want[5:3], want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_shr();
    step_t s[] = '{
      st(1, USR_LOAD, 0, 0, 4'b1011, 4'b1011, 3'd0, 0),
      st(1, USR_SHR,  0, 0, 4'b0000, 4'b0101, 3'd1, 0),
      st(1, USR_SHR,  0, 0, 4'b0000, 4'b0010, 3'd2, 0),
      st(1, USR_SHR,  0, 0, 4'b0000, 4'b0001, 3'd3, 0),
      st(1, USR_SHR,  0, 0, 4'b0000, 4'b0000, 3'd0, 1),
      st(1, USR_HOLD, 0, 0, 4'b0000, 4'b0000, 3'd0, 0)
    };
    run_steps("shr", s);
  endtask

  task automatic test_rotate();
    step_t s[] = '{
      st(1, USR_LOAD, 0, 0, 4'b1001, 4'b1001, 3'd0, 0),
      st(1, USR_ROL,  1, 1, 4'b0000, 4'b0011, 3'd1, 0),
      st(1, USR_ROL,  1, 1, 4'b0000, 4'b0110, 3'd2, 0),
      st(1, USR_ROR,  1, 1, 4'b0000, 4'b0011, 3'd3, 0),
      st(1, USR_ROR,  1, 1, 4'b0000, 4'b1001, 3'd0, 1),
      st(0, USR_ROR,  0, 0, 4'b0000, 4'b1001, 3'd0, 0)
    };
    run_steps("rotate", s);
  endtask

  task automatic test_asr();
    step_t s[] = '{
      st(1, USR_LOAD, 0, 0, 4'b1000, 4'b1000, 3'd0, 0),
      st(1, USR_ASR,  0, 1, 4'b0000, 4'b1100, 3'd1, 0),
      st(1, USR_ASR,  0, 1, 4'b0000, 4'b1110, 3'd2, 0),
      st(1, USR_ASR,  0, 0, 4'b0000, 4'b1111, 3'd3, 0),
      st(1, USR_LOAD, 0, 0, 4'b0100, 4'b0100, 3'd0, 0),
      st(1, USR_ASR,  0, 1, 4'b0000, 4'b0010, 3'd1, 0),
      st(1, USR_CLR,  0, 0, 4'b1111, 4'b0000, 3'd0, 0)
    };
    run_steps("asr", s);
  endtask

  task automatic test_gaps();
    step_t s[] = '{
      st(1, USR_CLR,  0, 0, 4'b0000, 4'b0000, 3'd0, 0),
      st(1, USR_SHL,  1, 0, 4'b0000, 4'b0001, 3'd1, 0),
      st(1, USR_SHL,  1, 0, 4'b0000, 4'b0011, 3'd2, 0),
      st(1, USR_SHL,  1, 0, 4'b0000, 4'b0111, 3'd3, 0),
      st(1, USR_HOLD, 1, 0, 4'b0000, 4'b0111, 3'd3, 0),
      st(1, USR_HOLD, 1, 0, 4'b0000, 4'b0111, 3'd3, 0),
      st(0, USR_SHL,  1, 0, 4'b0000, 4'b0111, 3'd3, 0),
      st(1, USR_SHL,  1, 0, 4'b0000, 4'b1111, 3'd0, 1),
      st(1, USR_SHL,  0, 0, 4'b0000, 4'b1110, 3'd1, 0),
      st(1, USR_SHL,  0, 0, 4'b0000, 4'b1100, 3'd2, 0),
      st(1, USR_SHL,  0, 0, 4'b0000, 4'b1000, 3'd3, 0),
      st(1, USR_LOAD, 0, 0, 4'b0101, 4'b0101, 3'd0, 0),
      st(1, USR_ROR,  0, 0, 4'b0000, 4'b1010, 3'd1, 0),
      st(1, USR_ROR,  0, 0, 4'b0000, 4'b0101, 3'd2, 0),
      st(1, USR_ROR,  0, 0, 4'b0000, 4'b1010, 3'd3, 0),
      st(1, USR_CLR,  0, 0, 4'b0000, 4'b0000, 3'd0, 0)
    };
    run_steps("gaps", s);
  endtask

  task automatic test_back_to_back();
    step_t s[] = '{
      st(1, USR_CLR, 0, 0, 4'b0000, 4'b0000, 3'd0, 0),
      st(1, USR_SHR, 0, 1, 4'b0000, 4'b1000, 3'd1, 0),
      st(1, USR_SHR, 0, 1, 4'b0000, 4'b1100, 3'd2, 0),
      st(1, USR_SHR, 0, 1, 4'b0000, 4'b1110, 3'd3, 0),
      st(1, USR_SHR, 0, 1, 4'b0000, 4'b1111, 3'd0, 1),
      st(1, USR_SHR, 0, 0, 4'b0000, 4'b0111, 3'd1, 0),
      st(1, USR_SHR, 0, 0, 4'b0000, 4'b0011, 3'd2, 0),
      st(1, USR_SHR, 0, 0, 4'b0000, 4'b0001, 3'd3, 0),
      st(1, USR_SHR, 0, 0, 4'b0000, 4'b0000, 3'd0, 1)
    };
    run_steps("back_to_back", s);
  endtask

  task automatic test_width8();
    logic [7:0] exp_q;
    int pulses = 0;
    @(negedge clk);
    ce8 = 1'b1; mode8 = USR_LOAD; d8 = 8'h81; s_left8 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q8 !== 8'h81 || shift_cnt8 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL w8_load got q=%h cnt=%0d want q=81 cnt=0", q8, shift_cnt8);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      mode8 = USR_SHL;
      @(posedge clk);
      #1;
      exp_q = 8'((16'h0081 << k) & 16'h00FF);
      if (word_done8) pulses++;
      checks++;
      if (q8 !== exp_q || shift_cnt8 !== 4'(k % 8) || word_done8 !== (k == 8)) begin
        failures++;
        $display("[TB] FAIL w8_shl k=%0d got q=%h cnt=%0d wd=%b want q=%h cnt=%0d wd=%b",
                 k, q8, shift_cnt8, word_done8, exp_q, k % 8, (k == 8));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL w8_pulses got=%0d want=1", pulses);
    end
    @(negedge clk);
    mode8 = USR_SHL;
    @(posedge clk);
    #1;
    @(negedge clk);
    mode8 = USR_CLR;
    @(posedge clk);
    #1;
    checks++;
    if (q8 !== 8'h00 || shift_cnt8 !== 4'd0 || word_done8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL w8_clr got q=%h cnt=%0d wd=%b want 0", q8, shift_cnt8, word_done8);
    end
    ce8 = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #3;
    test_reset();
    test_shr();
    test_rotate();
    test_asr();
    test_gaps();
    test_back_to_back();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
